// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared types for the MEM->WB boundary register: payload layout and
// elastic-buffer state encoding.
package mem_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEST_W = 4;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DEF_DATA_W-1:0] alu_res;
    logic [DEF_DATA_W-1:0] mem_data;
    logic [DEF_DEST_W-1:0] dest;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_reg_pipe_skid_buf.sv
// Payload-agnostic valid/ready elastic buffer: main register plus optional
// one-entry skid register, strictly FIFO.
//
// state   | meaning
// S_EMPTY | no valid entry
// S_ONE   | main valid, skid empty
// S_FULL  | main and skid valid (SKID_EN=1 only)
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int W       = 8,
  parameter int SKID_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic         pop;

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // With the skid entry, ready comes straight from a flop; without it, ready
  // follows out_ready combinationally.
  if (SKID_EN != 0) begin : g_skid
    assign in_ready = in_ready_q & ~rst;
  end else begin : g_noskid
    assign in_ready = ~rst & ((state_q == S_EMPTY) | out_ready);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          main_d = in_data;
        end else if (accept && (SKID_EN != 0)) begin
          skid_d  = in_data;
          state_d = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline boundary register: elastic handshake buffer plus the
// writeback value select and gated register-file write strobe.
module mem_wb_skid_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 4,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] wb_value,
  output logic              rf_we
);

  // Same layout as mem_wb_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
    logic [DEST_W-1:0] dest;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  payload_t in_pl;
  payload_t out_pl;

  assign in_pl.wb_en    = wb_en_in;
  assign in_pl.mem_r_en = mem_r_en_in;
  assign in_pl.alu_res  = alu_res_in;
  assign in_pl.mem_data = mem_data_in;
  assign in_pl.dest     = dest_in;

  pipe_skid_buf #(
    .W       (PAYLOAD_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign wb_en_out    = out_pl.wb_en & out_valid;
  assign mem_r_en_out = out_pl.mem_r_en;
  assign alu_res_out  = out_pl.alu_res;
  assign mem_data_out = out_pl.mem_data;
  assign dest_out     = out_pl.dest;
  assign wb_value     = out_pl.mem_r_en ? out_pl.mem_data : out_pl.alu_res;
  assign rf_we        = out_valid & out_ready & wb_en_out;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: one instance with the skid entry,
// one without, sharing clock, reset, flush and payload inputs.
module tb_mem_wb_skid_reg;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic in_valid, out_ready, in_valid0, out_ready0;
  logic wb_en_in, mem_r_en_in;
  logic [DW-1:0] alu_res_in, mem_data_in;
  logic [AW-1:0] dest_in;

  logic in_ready, out_valid, wb_en_out, mem_r_en_out, rf_we;
  logic [DW-1:0] alu_res_out, mem_data_out, wb_value;
  logic [AW-1:0] dest_out;
  logic in_ready0, out_valid0, wb_en_out0, mem_r_en_out0, rf_we0;
  logic [DW-1:0] alu_res_out0, mem_data_out0, wb_value0;
  logic [AW-1:0] dest_out0;

  typedef struct packed {
    logic          wb_en;
    logic          mem_r_en;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [AW-1:0] dest;
  } pl_t;

  pl_t sb[$];
  pl_t sb0[$];
  int  occ, occ0;
  int  checks = 0;
  int  errors = 0;

  mem_wb_skid_reg #(.DATA_W(DW), .DEST_W(AW), .SKID_EN(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_res_in(alu_res_in),
    .mem_data_in(mem_data_in), .dest_in(dest_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .wb_value(wb_value), .rf_we(rf_we)
  );

  mem_wb_skid_reg #(.DATA_W(DW), .DEST_W(AW), .SKID_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_res_in(alu_res_in),
    .mem_data_in(mem_data_in), .dest_in(dest_in), .out_valid(out_valid0),
    .out_ready(out_ready0), .wb_en_out(wb_en_out0), .mem_r_en_out(mem_r_en_out0),
    .alu_res_out(alu_res_out0), .mem_data_out(mem_data_out0), .dest_out(dest_out0),
    .wb_value(wb_value0), .rf_we(rf_we0)
  );

  task automatic set_pl(input logic we, input logic mr, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mem, input logic [AW-1:0] dest);
    wb_en_in    = we;
    mem_r_en_in = mr;
    alu_res_in  = alu;
    mem_data_in = mem;
    dest_in     = dest;
  endtask

  function automatic pl_t cur_pl();
    pl_t p;
    p.wb_en = wb_en_in; p.mem_r_en = mem_r_en_in; p.alu = alu_res_in;
    p.mem = mem_data_in; p.dest = dest_in;
    return p;
  endfunction

  // Reference behaviour of the skid instance: occupancy 0..2, FIFO order.
  task automatic model_adv(input logic rdy);
    logic acc, pp;
    acc = in_valid & rdy;
    pp  = (occ != 0) & out_ready;
    if (pp) void'(sb.pop_front());
    if (flush) begin
      sb.delete();
      occ = 0;
    end else begin
      if (acc) sb.push_back(cur_pl());
      occ = occ + int'(acc) - int'(pp);
    end
  endtask

  // Reference behaviour of the single-entry instance.
  task automatic model_adv0(input logic rdy);
    logic acc, pp;
    acc = in_valid0 & rdy;
    pp  = (occ0 != 0) & out_ready0;
    if (pp) void'(sb0.pop_front());
    if (flush) begin
      sb0.delete();
      occ0 = 0;
    end else begin
      if (acc) sb0.push_back(cur_pl());
      occ0 = occ0 + int'(acc) - int'(pp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_valid0 = 1'b1; out_ready = 1'b1; out_ready0 = 1'b1;
    set_pl(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_we !== 1'b0 || wb_en_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl: ov=%b ir=%b rf_we=%b wb_en=%b, required all 0",
                 out_valid, in_ready, rf_we, wb_en_out);
      end
      checks++;
      if (wb_value !== '0 || alu_res_out !== '0 || mem_data_out !== '0 ||
          dest_out !== '0 || mem_r_en_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_data: wb_value=%h alu=%h mem=%h dest=%h mr=%b, required 0",
                 wb_value, alu_res_out, mem_data_out, dest_out, mem_r_en_out);
      end
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0 || rf_we0 !== 1'b0 || wb_value0 !== '0) begin
        errors++;
        $display("FAIL reset_noskid: ov=%b ir=%b rf_we=%b wbv=%h, required 0",
                 out_valid0, in_ready0, rf_we0, wb_value0);
      end
    end
    rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ir=%b ir0=%b, required 1 1", in_ready, in_ready0);
    end
    occ = 0; occ0 = 0;
    sb.delete(); sb0.delete();
    @(negedge clk);
  endtask

  // One skid-instance cycle: inputs already driven, compare then advance.
  // Inlined into each scenario loop below.
  task automatic test_streaming();
    logic rdy;
    pl_t  h;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      set_pl(1'b1, 1'b0, DW'(32'h10 * (c + 1)), 32'h0, AW'(c + 1));
      #1;
      rdy = (occ != 2);
      checks++;
      if (in_ready !== rdy || out_valid !== (occ != 0)) begin
        errors++;
        $display("FAIL stream_hs c%0d: ir=%b ov=%b, required %b %b", c, in_ready, out_valid, rdy, occ != 0);
      end
      if (occ != 0) begin
        h = sb[0];
        checks++;
        if (wb_value !== (h.mem_r_en ? h.mem : h.alu) || dest_out !== h.dest ||
            rf_we !== (out_ready & h.wb_en)) begin
          errors++;
          $display("FAIL stream_data c%0d: wbv=%h dest=%h rf_we=%b, required %h %h %b", c,
                   wb_value, dest_out, rf_we, h.mem_r_en ? h.mem : h.alu, h.dest, out_ready & h.wb_en);
        end
      end else begin
        checks++;
        if (rf_we !== 1'b0 || wb_en_out !== 1'b0) begin
          errors++;
          $display("FAIL stream_idle c%0d: rf_we=%b wb_en=%b, required 0 0", c, rf_we, wb_en_out);
        end
      end
      model_adv(rdy);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    pl_t  h;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin in_valid = 1'b1; out_ready = 1'b0; set_pl(1'b1, 1'b0, 32'hA, 32'h0, 4'd3); end
        1: begin in_valid = 1'b1; out_ready = 1'b0; set_pl(1'b1, 1'b0, 32'hB, 32'h0, 4'd5); end
        2: begin in_valid = 1'b1; out_ready = 1'b0; set_pl(1'b1, 1'b0, 32'hC, 32'h0, 4'd7); end
        default: begin in_valid = 1'b0; out_ready = 1'b1; end
      endcase
      #1;
      rdy = (occ != 2);
      checks++;
      if (in_ready !== rdy || out_valid !== (occ != 0)) begin
        errors++;
        $display("FAIL bp_hs c%0d: ir=%b ov=%b, required %b %b", c, in_ready, out_valid, rdy, occ != 0);
      end
      if (occ != 0) begin
        h = sb[0];
        checks++;
        if (wb_value !== h.alu || dest_out !== h.dest || rf_we !== (out_ready & h.wb_en)) begin
          errors++;
          $display("FAIL bp_data c%0d: wbv=%h dest=%h rf_we=%b, required %h %h %b", c,
                   wb_value, dest_out, rf_we, h.alu, h.dest, out_ready & h.wb_en);
        end
      end
      if (c == 2) begin
        checks++;
        if (in_ready !== 1'b0 || dest_out !== 4'd3) begin
          errors++;
          $display("FAIL bp_full: ir=%b dest=%h, required 0 3", in_ready, dest_out);
        end
      end
      model_adv(rdy);
      @(negedge clk);
    end
  endtask

  task automatic test_load_select();
    logic rdy;
    pl_t  h;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = (c < 2);
      set_pl(1'b1, (c == 0), 32'h0000_1000, 32'hDEAD_BEEF, 4'd9);
      #1;
      rdy = (occ != 2);
      if (occ != 0) begin
        h = sb[0];
        checks++;
        if (wb_value !== (h.mem_r_en ? h.mem : h.alu) || mem_r_en_out !== h.mem_r_en) begin
          errors++;
          $display("FAIL load_sel c%0d: wbv=%h mr=%b, required %h %b", c, wb_value, mem_r_en_out,
                   h.mem_r_en ? h.mem : h.alu, h.mem_r_en);
        end
      end
      if (c == 1) begin
        checks++;
        if (wb_value !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL load_mem: wbv=%h, required deadbeef", wb_value);
        end
      end
      if (c == 2) begin
        checks++;
        if (wb_value !== 32'h0000_1000) begin
          errors++;
          $display("FAIL load_alu: wbv=%h, required 00001000", wb_value);
        end
      end
      model_adv(rdy);
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic rdy;
    pl_t  h;
    for (int c = 0; c < 6; c++) begin
      flush = 1'b0;
      case (c)
        0: begin in_valid = 1'b1; out_ready = 1'b0; set_pl(1'b1, 1'b0, 32'h111, 32'h0, 4'd1); end
        1: begin in_valid = 1'b1; out_ready = 1'b0; set_pl(1'b1, 1'b0, 32'h222, 32'h0, 4'd2); end
        2: begin in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1; set_pl(1'b1, 1'b0, 32'hD0D, 32'h0, 4'd13); end
        3: begin in_valid = 1'b0; out_ready = 1'b1; end
        default: begin in_valid = 1'b0; out_ready = 1'b1; end
      endcase
      #1;
      rdy = (occ != 2);
      checks++;
      if (in_ready !== rdy || out_valid !== (occ != 0)) begin
        errors++;
        $display("FAIL flush_hs c%0d: ir=%b ov=%b, required %b %b", c, in_ready, out_valid, rdy, occ != 0);
      end
      if (occ != 0) begin
        h = sb[0];
        checks++;
        if (wb_value !== h.alu || rf_we !== (out_ready & h.wb_en)) begin
          errors++;
          $display("FAIL flush_data c%0d: wbv=%h rf_we=%b, required %h %b", c, wb_value, rf_we,
                   h.alu, out_ready & h.wb_en);
        end
      end else begin
        checks++;
        if (rf_we !== 1'b0 || wb_en_out !== 1'b0) begin
          errors++;
          $display("FAIL flush_idle c%0d: rf_we=%b wb_en=%b, required 0 0", c, rf_we, wb_en_out);
        end
      end
      model_adv(rdy);
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  task automatic test_no_skid();
    logic rdy;
    pl_t  h;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin in_valid0 = 1'b1; out_ready0 = 1'b0; set_pl(1'b1, 1'b0, 32'h51, 32'h0, 4'd4); end
        1: begin in_valid0 = 1'b1; out_ready0 = 1'b0; set_pl(1'b1, 1'b0, 32'h52, 32'h0, 4'd6); end
        2: begin in_valid0 = 1'b1; out_ready0 = 1'b1; set_pl(1'b1, 1'b0, 32'h52, 32'h0, 4'd6); end
        3: begin in_valid0 = 1'b1; out_ready0 = 1'b1; set_pl(1'b0, 1'b1, 32'h53, 32'h77, 4'd8); end
        default: begin in_valid0 = 1'b0; out_ready0 = 1'b1; end
      endcase
      #1;
      rdy = (occ0 == 0) | out_ready0;
      checks++;
      if (in_ready0 !== rdy || out_valid0 !== (occ0 != 0)) begin
        errors++;
        $display("FAIL noskid_hs c%0d: ir=%b ov=%b, required %b %b", c, in_ready0, out_valid0, rdy, occ0 != 0);
      end
      if (occ0 != 0) begin
        h = sb0[0];
        checks++;
        if (wb_value0 !== (h.mem_r_en ? h.mem : h.alu) || dest_out0 !== h.dest ||
            rf_we0 !== (out_ready0 & h.wb_en) || wb_en_out0 !== h.wb_en) begin
          errors++;
          $display("FAIL noskid_data c%0d: wbv=%h dest=%h rf_we=%b wb_en=%b, required %h %h %b %b", c,
                   wb_value0, dest_out0, rf_we0, wb_en_out0, h.mem_r_en ? h.mem : h.alu, h.dest,
                   out_ready0 & h.wb_en, h.wb_en);
        end
      end else begin
        checks++;
        if (rf_we0 !== 1'b0 || wb_en_out0 !== 1'b0) begin
          errors++;
          $display("FAIL noskid_idle c%0d: rf_we=%b wb_en=%b, required 0 0", c, rf_we0, wb_en_out0);
        end
      end
      model_adv0(rdy);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    test_streaming();
    test_backpressure();
    test_load_select();
    test_flush();
    test_no_skid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
